pcie_wrap0_st_channel_arbiter: RTL and testbench
================================================

Name: pcie_wrap0_st_channel_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one Avalon-ST byte link among NUM_CH packet sources.
- Grant is held from the start-of-packet (SOP) beat to the end-of-packet (EOP) beat.
- The winning source index is driven on out_channel; output feeds the master's channelised byte-stream path.
- One registered output stage with full-throughput ready/valid.

Parameters:
NUM_CH, 4, number of requesting sources (2..16)
DATA_W, 8, beat data width in bits
CH_W, 8, out_channel width; index zero-extended (CH_W >= clog2(NUM_CH))

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  NUM_CH  per-source beat valid
in_data  input  NUM_CH*DATA_W  per-source data; source i at [i*DATA_W +: DATA_W]
in_startofpacket  input  NUM_CH  per-source SOP
in_endofpacket  input  NUM_CH  per-source EOP
in_ready  output  NUM_CH  per-source ready
out_ready  input  1  downstream ready
out_valid  output  1  registered beat valid
out_data  output  DATA_W  registered data
out_startofpacket  output  1  registered SOP
out_endofpacket  output  1  registered EOP
out_channel  output  CH_W  index of the source that produced the beat
busy  output  1  high while in LOCKED state
proto_err  output  1  sticky protocol-error flag; cleared only by reset

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, owner=0, all out_* regs=0, proto_err=0, in_ready=0.
- load = out_ready | ~out_valid. This is the output register enable.
- States: IDLE, LOCKED.
- IDLE: in_ready=0. If any in_valid is set, the winner is the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_CH. Next cycle: owner=winner, state=LOCKED.
  - Arbitration costs exactly 1 cycle; no beat is accepted in IDLE.
- LOCKED: in_ready[owner]=load; all other in_ready=0.
  - Beat accepted when in_valid[owner] & in_ready[owner].
  - On accept: out_data/sop/eop take the owner's inputs, out_channel=owner, out_valid=1. Latency from accept to visible output: 1 cycle.
  - On accept with EOP=1: state=IDLE, rr_ptr=(owner+1) mod NUM_CH. A single-beat packet (SOP=EOP=1) is legal.
- Output register: when load=1 and no beat is accepted this cycle, out_valid becomes 0. When load=0, all out_* hold their values.
- Throughput:
  - 1 beat/clk within a packet.
  - 1 idle clk between packets (re-arbitration bubble), even when the same source re-requests.
- Fairness: a source that just finished is lowest priority in the next arbitration. No source waits more than NUM_CH-1 packets.
- in_valid may drop mid-packet: the grant is held and no beat is emitted. Other requesters are never serviced mid-packet.
- Protocol errors (beat is still forwarded unchanged):
  - proto_err sets if the first accepted beat after grant has SOP=0.
  - proto_err sets if a later beat in the same packet has SOP=1.
- Simultaneous out_ready=0 and an owner beat: the beat is not accepted and in_ready stays low. No data loss or duplication.
- Reset mid-packet: the packet is abandoned, outputs clear immediately, and arbitration restarts from rr_ptr=0.
- out_channel upper bits (above clog2(NUM_CH)) are always 0.

Test Plan:
- Single source: src2 sends a 3-beat packet 0x11,0x22,0x33 (SOP on beat 1, EOP on beat 3), out_ready=1 -> out beats 0x11/SOP, 0x22, 0x33/EOP with out_channel=2; first out_valid 2 clk after src2 in_valid rises; busy falls after the EOP accept.
- Round-robin: all 4 sources hold single-beat packets continuously from reset -> out_channel sequence 0,1,2,3,0,1..., one beat every 2 clk.
- Grant lock: src0 sends a 4-beat packet and src1 asserts valid mid-packet -> all 4 src0 beats are contiguous on the output before any src1 beat; src1 follows with out_channel=1.
- Backpressure: out_ready toggles 1,0,0,1 during a 5-beat packet -> output order and data are exact, out_* are stable while out_ready=0, and in_ready[owner]=0 while out_valid=1 and out_ready=0.
- Protocol error: src3's first beat has SOP=0, data 0xA5 -> beat is forwarded with out_channel=3, proto_err=1 and stays set until reset_n=0.
- Reset mid-packet: assert reset_n=0 after beat 2 of a 4-beat packet -> out_valid=0 and busy=0 asynchronously; after release, the first grant goes to the lowest valid index ≥ 0.

Source files
------------

// File: rtl/pcie_wrap0_st_channel_arbiter_if.sv
// Avalon-ST bundle between NUM_CH packet sources, the channel arbiter and the
// shared downstream byte link.
interface pcie_wrap0_st_channel_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_W   = 8
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_startofpacket;
  logic [NUM_CH-1:0]        in_endofpacket;
  logic [NUM_CH-1:0]        in_ready;

  logic                     out_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CH_W-1:0]          out_channel;

  modport slave (
    input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
           out_channel
  );

  modport master (
    output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
           out_channel
  );
endinterface

// File: rtl/pcie_wrap0_st_channel_arbiter.sv
// Packet-aware round-robin arbiter: one source owns the output link from its
// SOP beat to its EOP beat; beats pass through a single registered stage.
module pcie_wrap0_st_channel_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_W   = 8
) (
  input  logic clk,
  input  logic reset_n,
  pcie_wrap0_st_channel_arbiter_if.slave st,
  output logic busy,
  output logic proto_err
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              first_q, first_d;
  logic              proto_err_q, proto_err_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [IDX_W-1:0]  out_ch_q, out_ch_d;

  logic              load;
  logic              accept;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  owner_next;
  logic              own_valid;
  logic              own_sop;
  logic              own_eop;
  logic [DATA_W-1:0] own_data;

  assign load      = st.out_ready | ~out_valid_q;
  assign own_valid = st.in_valid[owner_q];
  assign own_sop   = st.in_startofpacket[owner_q];
  assign own_eop   = st.in_endofpacket[owner_q];
  assign own_data  = st.in_data[32'(owner_q) * DATA_W +: DATA_W];
  assign accept    = (state_q == LOCKED) & own_valid & load;

  // Owner index wraps explicitly so non-power-of-two NUM_CH stays in range.
  assign owner_next = (owner_q == IDX_W'(NUM_CH - 1)) ? '0 : owner_q + 1'b1;

  // First requester at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_CH);
      if (!win_found && st.in_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    st.in_ready = '0;
    if (state_q == LOCKED) begin
      st.in_ready[owner_q] = load;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    first_d     = first_q;
    proto_err_d = proto_err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_ch_d    = out_ch_q;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          first_d = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) begin
          first_d = 1'b0;
          // The first beat must carry SOP; no later beat may.
          if ((first_q && !own_sop) || (!first_q && own_sop)) begin
            proto_err_d = 1'b1;
          end
          if (own_eop) begin
            state_d  = IDLE;
            rr_ptr_d = owner_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = own_data;
        out_sop_d  = own_sop;
        out_eop_d  = own_eop;
        out_ch_d   = owner_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      first_q     <= 1'b0;
      proto_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      first_q     <= first_d;
      proto_err_q <= proto_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign st.out_valid         = out_valid_q;
  assign st.out_data          = out_data_q;
  assign st.out_startofpacket = out_sop_q;
  assign st.out_endofpacket   = out_eop_q;
  assign st.out_channel       = CH_W'(out_ch_q);
  assign busy                 = (state_q == LOCKED);
  assign proto_err            = proto_err_q;

endmodule

// File: tb/tb_pcie_wrap0_st_channel_arbiter.sv
// Scoreboard bench for the channel arbiter: per-source beat queues feed the
// inputs, expected output beats are queued in the order they must appear.
module tb_pcie_wrap0_st_channel_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CH_W   = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [CH_W-1:0]   ch;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  logic proto_err;

  pcie_wrap0_st_channel_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  pcie_wrap0_st_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .st        (bus),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned cyc     = 0;
  int unsigned rx_cnt  = 0;

  exp_t              sb_q[$];
  logic [DATA_W+1:0] src_mem [NUM_CH][64];
  int unsigned       src_cnt [NUM_CH];
  int unsigned       src_ptr [NUM_CH];
  logic [NUM_CH-1:0] drv_acc;

  logic              gap_chk = 1'b0;
  logic              gap_first;
  int unsigned       last_cyc;
  logic              prev_stall = 1'b0;
  logic [31:0]       held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Queue one beat at a source and record where it must appear on the output.
  task automatic send_beat(input int unsigned src, input logic [DATA_W-1:0] d,
                           input logic sop, input logic eop);
    exp_t e;
    src_mem[src][src_cnt[src]] = {sop, eop, d};
    src_cnt[src]++;
    e.data = d; e.sop = sop; e.eop = eop; e.ch = CH_W'(src);
    sb_q.push_back(e);
  endtask

  function automatic logic srcs_done();
    for (int i = 0; i < NUM_CH; i++) if (src_ptr[i] != src_cnt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string tag);
    int unsigned t = 0;
    while ((sb_q.size() != 0 || !srcs_done()) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NUM_CH; i++) begin
      src_cnt[i] = 0;
      src_ptr[i] = 0;
    end
  endtask

  // Source driver: advance a source's queue after each accepted beat.
  initial begin
    bus.in_valid         = '0;
    bus.in_data          = '0;
    bus.in_startofpacket = '0;
    bus.in_endofpacket   = '0;
    forever begin
      @(negedge clk);
      drv_acc = bus.in_valid & bus.in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (drv_acc[i] && src_ptr[i] < src_cnt[i]) src_ptr[i]++;
        if (src_ptr[i] < src_cnt[i]) begin
          bus.in_valid[i]                 = 1'b1;
          bus.in_startofpacket[i]         = src_mem[i][src_ptr[i]][DATA_W+1];
          bus.in_endofpacket[i]           = src_mem[i][src_ptr[i]][DATA_W];
          bus.in_data[i*DATA_W +: DATA_W] = src_mem[i][src_ptr[i]][DATA_W-1:0];
        end else begin
          bus.in_valid[i]                 = 1'b0;
          bus.in_startofpacket[i]         = 1'b0;
          bus.in_endofpacket[i]           = 1'b0;
          bus.in_data[i*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

  // Output monitor: beats transferring at the next edge are compared here.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check_eq("stall_hold", {bus.out_data, bus.out_startofpacket, bus.out_endofpacket,
                                14'd0, bus.out_channel}, held);
      end
      prev_stall = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
        held = {bus.out_data, bus.out_startofpacket, bus.out_endofpacket, 14'd0, bus.out_channel};
        prev_stall = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_beat", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("out_data",    32'(bus.out_data), 32'(e.data));
          check_eq("out_sop",     32'(bus.out_startofpacket), 32'(e.sop));
          check_eq("out_eop",     32'(bus.out_endofpacket), 32'(e.eop));
          check_eq("out_channel", 32'(bus.out_channel), 32'(e.ch));
        end
        if (gap_chk) begin
          if (!gap_first) check_eq("rr_gap", cyc - last_cyc, 32'd2);
          gap_first = 1'b0;
        end
        last_cyc = cyc;
        rx_cnt++;
      end
    end
  end

  initial begin
    int unsigned n;
    int unsigned base;
    int unsigned k;
    logic [3:0] bp_pat;

    clear_sources();
    reset_n       = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_busy",      32'(busy), 32'd0);
    check_eq("rst_proto_err", 32'(proto_err), 32'd0);
    check_eq("rst_in_ready",  32'(bus.in_ready), 32'd0);
    check_eq("rst_channel",   32'(bus.out_channel), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Round-robin: all sources request single-beat packets from reset.
    gap_first = 1'b1;
    gap_chk   = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_CH; i++)
        send_beat(i, DATA_W'(8'h40 + r * 16 + i), 1'b1, 1'b1);
    wait_drain("rr_drain");
    gap_chk = 1'b0;

    // Single source: three beats from source 2.
    send_beat(2, 8'h11, 1'b1, 1'b0);
    send_beat(2, 8'h22, 1'b0, 1'b0);
    send_beat(2, 8'h33, 1'b0, 1'b1);
    n = 0;
    while (!bus.in_valid[2] && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 10);
    check_eq("first_latency", n, 32'd2);
    check_eq("busy_mid_pkt", 32'(busy), 32'd1);
    n = 0;
    while (!(bus.out_valid && bus.out_endofpacket) && n < 20) begin @(negedge clk); n++; end
    check_eq("busy_after_eop", 32'(busy), 32'd0);
    wait_drain("single_drain");

    // Grant lock: source 1 requests while source 0 is mid-packet.
    for (int j = 0; j < 4; j++) send_beat(0, DATA_W'(8'h20 + j), j == 0, j == 3);
    repeat (3) @(negedge clk);
    send_beat(1, 8'h30, 1'b1, 1'b0);
    send_beat(1, 8'h31, 1'b0, 1'b1);
    wait_drain("lock_drain");

    // Backpressure: out_ready cycles 1,0,0,1 over a 5-beat packet.
    bp_pat = 4'b1001;
    for (int j = 0; j < 5; j++) send_beat(2, DATA_W'(8'h60 + j), j == 0, j == 4);
    k = 0;
    while ((sb_q.size() != 0 || !srcs_done()) && k < 200) begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_pat[3 - (k % 4)];
      k++;
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain("bp_drain");
    check_eq("proto_ok", 32'(proto_err), 32'd0);

    // Reset mid-packet: abandon source 0 after its second beat.
    base = rx_cnt;
    for (int j = 0; j < 4; j++) send_beat(0, DATA_W'(8'h70 + j), j == 0, j == 3);
    k = 0;
    while (rx_cnt < base + 2 && k < 100) begin @(posedge clk); k++; end
    check_eq("pre_reset_beats", rx_cnt - base, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("async_busy",      32'(busy), 32'd0);
    sb_q.delete();
    clear_sources();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_beat(1, 8'h81, 1'b1, 1'b1);
    send_beat(3, 8'h83, 1'b1, 1'b1);
    wait_drain("post_reset_drain");

    // Protocol error: first beat without SOP, then sticky until reset.
    send_beat(3, 8'hA5, 1'b0, 1'b1);
    wait_drain("perr_drain");
    check_eq("proto_err_set", 32'(proto_err), 32'd1);
    send_beat(0, 8'h5A, 1'b1, 1'b1);
    wait_drain("perr_hold_drain");
    check_eq("proto_err_sticky", 32'(proto_err), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("proto_err_clr", 32'(proto_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Protocol error: SOP repeated on a later beat.
    send_beat(0, 8'hC0, 1'b1, 1'b0);
    send_beat(0, 8'hC1, 1'b1, 1'b1);
    wait_drain("perr2_drain");
    check_eq("proto_err_sop2", 32'(proto_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
